// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage of the RV32 multicycle core.
//
// Holds the architectural PC, drives it straight onto the instruction memory
// address, and captures the combinational read data into the instruction
// register (IR). The IR and the PC it came from are offered to decode over a
// valid/ready handshake. Execute may redirect the PC at any time until a
// misaligned or out-of-range fetch is detected. From then on the unit stays
// in a terminal fault state until reset.
//
// Ports
//   clk             clock, all state changes on the rising edge
//   resetn          synchronous, active-low reset
//   imem_addr       byte address to instruction memory (always the PC register)
//   imem_rdata      instruction word read combinationally at imem_addr
//   ir_valid        ir / ir_pc hold an instruction for decode
//   ir_ready        decode accepts the instruction this cycle
//   ir              latched instruction
//   ir_pc           byte address the instruction was fetched from
//   redirect_valid  single-cycle request to load redirect_pc into the PC
//   redirect_pc     redirect target
//   fetch_fault     sticky fault flag
//   fault_pc        PC that caused the fault
//   fetch_count     number of accepted handshakes (wraps at 2^32)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } state_t;

  // The range check is done on 33 bits so a PC near 2^32 cannot wrap past the
  // limit and look legal.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ir_nxt, ir_pc_nxt;
  logic        fault_nxt;
  logic [31:0] fault_pc_nxt;
  logic [31:0] fetch_count_nxt;

  logic [32:0] pc_last_byte;
  logic        fetch_bad;

  assign pc_last_byte = {1'b0, pc} + 33'd3;
  assign fetch_bad    = (pc[1:0] != 2'b00) || (pc_last_byte >= MEM_LIMIT);

  // The memory address comes from the PC flop only; a redirect reaches the
  // memory one cycle later, never combinationally.
  assign imem_addr = pc;
  assign ir_valid  = (state == VALID);

  // Next-state and datapath decision. Priority: redirect, then fault check,
  // then the normal FETCH/VALID action. FAULT ignores everything but reset.
  always_comb begin
    // NOTE: every signal driven here gets a hold default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    ir_nxt          = ir;
    ir_pc_nxt       = ir_pc;
    fault_nxt       = fetch_fault;
    fault_pc_nxt    = fault_pc;
    fetch_count_nxt = fetch_count;

    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          // Redirect target is not checked here; it faults on the next FETCH.
          pc_nxt = redirect_pc;
        end else if (fetch_bad) begin
          state_nxt    = FAULT;
          fault_nxt    = 1'b1;
          fault_pc_nxt = pc;
        end else begin
          ir_nxt    = imem_rdata;
          ir_pc_nxt = pc;
          pc_nxt    = pc + 32'd4;
          state_nxt = VALID;
        end
      end

      VALID: begin
        // A handshake coinciding with a redirect still counts: decode keeps
        // that instruction, only the refetch target changes.
        if (ir_ready) begin
          fetch_count_nxt = fetch_count + 32'd1;
        end
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end else if (ir_ready) begin
          state_nxt = FETCH;
        end
      end

      FAULT: begin
        // Terminal: PC frozen so imem_addr keeps showing the faulting address.
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // State register and datapath registers. Reset is synchronous and wins
  // over every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= NOP_INSTR;
      ir_pc       <= 32'd0;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the pre-edge state, independent of statement order.
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      ir_pc       <= ir_pc_nxt;
      fetch_fault <= fault_nxt;
      fault_pc    <= fault_pc_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// A byte-addressed instruction memory answers imem_addr combinationally.
// A behavioural model of the fetch stage tracks what the outputs must be
// and is compared against the DUT on every falling edge after the first
// reset. Directed sequences drive the stimulus, and literal expectations
// taken straight from the intended behaviour pin the model down.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned MEM_BYTES = 1024;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        resetn;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .MEM_BYTES(MEM_BYTES),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Instruction memory (little-endian bytes)
  // ------------------------------------------------------------------
  logic [7:0] mem_b [0:MEM_BYTES-1];

  task automatic put_word(input int unsigned a, input logic [31:0] w);
    mem_b[a]     = w[7:0];
    mem_b[a + 1] = w[15:8];
    mem_b[a + 2] = w[23:16];
    mem_b[a + 3] = w[31:24];
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    if (la + 3 < longint'(MEM_BYTES))
      return {mem_b[la + 3], mem_b[la + 2], mem_b[la + 1], mem_b[la]};
    else
      return 32'hDEAD_BEEF;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  initial begin
    for (int i = 0; i < int'(MEM_BYTES / 4); i++)
      put_word(i * 4, 32'hC0DE_0000 | 32'(i));
    put_word(32'h000, 32'h0000_2083);
    put_word(32'h004, 32'h0010_8133);
    put_word(32'h030, 32'h0095_0A63);
    put_word(32'h3FC, 32'h0000_006F);
  end

  // ------------------------------------------------------------------
  // Behavioural model: "holding an instruction" / "dead" flags plus the
  // architectural values, advanced once per rising edge.
  // ------------------------------------------------------------------
  bit          started = 0;
  bit          m_holding;
  bit          m_dead;
  logic [31:0] m_pc, m_ir, m_ir_pc, m_fault_pc, m_count;

  always @(posedge clk) begin
    if (!resetn) begin
      started    = 1;
      m_holding  = 0;
      m_dead     = 0;
      m_pc       = RESET_PC;
      m_ir       = NOP_INSTR;
      m_ir_pc    = 0;
      m_fault_pc = 0;
      m_count    = 0;
    end else if (started && !m_dead) begin
      if (m_holding && ir_ready) m_count = m_count + 1;
      if (redirect_valid) begin
        m_pc      = redirect_pc;
        m_holding = 0;
      end else if (m_holding) begin
        if (ir_ready) m_holding = 0;
      end else if ((m_pc % 4) != 0 ||
                   longint'(m_pc) + 3 >= longint'(MEM_BYTES)) begin
        m_dead     = 1;
        m_fault_pc = m_pc;
      end else begin
        m_ir      = mem_word(m_pc);
        m_ir_pc   = m_pc;
        m_pc      = m_pc + 4;
        m_holding = 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("m.imem_addr",   imem_addr,          m_pc);
      check("m.ir_valid",    {31'd0, ir_valid},   {31'd0, m_holding});
      check("m.ir",          ir,                 m_ir);
      check("m.ir_pc",       ir_pc,              m_ir_pc);
      check("m.fetch_fault", {31'd0, fetch_fault}, {31'd0, m_dead});
      check("m.fault_pc",    fault_pc,           m_fault_pc);
      check("m.fetch_count", fetch_count,        m_count);
    end
  end

  // ------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    cyc(1);
    check("rst.fault", {31'd0, fetch_fault}, 32'd0);
    check("rst.pc",    imem_addr,            RESET_PC);
    check("rst.valid", {31'd0, ir_valid},    32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    resetn         = 1'b0;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    cyc(1);
    check("rst.ir",    ir,                32'h0000_0013);
    check("rst.ir_pc", ir_pc,             32'd0);
    check("rst.count", fetch_count,       32'd0);
    check("rst.valid", {31'd0, ir_valid}, 32'd0);

    // Streaming with ir_ready held high
    resetn   = 1'b1;
    ir_ready = 1'b1;
    cyc(1);
    check("st.valid1", {31'd0, ir_valid}, 32'd1);
    check("st.ir1",    ir,                32'h0000_2083);
    check("st.irpc1",  ir_pc,             32'd0);
    cyc(1);
    check("st.valid2", {31'd0, ir_valid}, 32'd0);
    check("st.addr2",  imem_addr,         32'd4);
    cyc(1);
    check("st.valid3", {31'd0, ir_valid}, 32'd1);
    check("st.ir3",    ir,                32'h0010_8133);
    check("st.irpc3",  ir_pc,             32'd4);
    cyc(1);
    check("st.count",  fetch_count,       32'd2);

    // Backpressure: hold the first instruction for 5 cycles
    ir_ready = 1'b0;
    do_reset();
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", {31'd0, ir_valid}, 32'd1);
      check("bp.ir",    ir,                32'h0000_2083);
      check("bp.irpc",  ir_pc,             32'd0);
      check("bp.count", fetch_count,       32'd0);
      cyc(1);
    end
    ir_ready = 1'b1;
    cyc(1);
    check("bp.addr",   imem_addr,   32'd4);
    check("bp.count1", fetch_count, 32'd1);
    ir_ready = 1'b0;
    cyc(1);
    check("bp.irpc4",  ir_pc,       32'd4);

    // Redirect in VALID without a handshake
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    cyc(1);
    redirect_valid = 1'b0;
    check("rd.valid0", {31'd0, ir_valid}, 32'd0);
    check("rd.count",  fetch_count,       32'd1);
    cyc(1);
    check("rd.ir",     ir,                32'h0095_0A63);
    check("rd.irpc",   ir_pc,             32'h30);
    check("rd.count2", fetch_count,       32'd1);

    // Redirect coinciding with a handshake: still counted; target 0x3FC legal
    ir_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FC;
    cyc(1);
    redirect_valid = 1'b0;
    ir_ready       = 1'b0;
    check("rh.count", fetch_count, 32'd2);
    cyc(1);
    check("rh.ir",    ir,                32'h0000_006F);
    check("rh.irpc",  ir_pc,             32'h3FC);
    check("rh.fault", {31'd0, fetch_fault}, 32'd0);
    // Sequential fetch walks off the end of memory
    ir_ready = 1'b1;
    cyc(2);
    check("end.fault",   {31'd0, fetch_fault}, 32'd1);
    check("end.faultpc", fault_pc,             32'h400);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc(2);
    redirect_valid = 1'b0;
    check("end.frozen",  imem_addr, 32'h400);

    // Misaligned redirect, then ignored redirects, then reset clears it
    ir_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    cyc(1);
    redirect_valid = 1'b0;
    check("mis.nofault", {31'd0, fetch_fault}, 32'd0);
    cyc(1);
    check("mis.fault",   {31'd0, fetch_fault}, 32'd1);
    check("mis.faultpc", fault_pc,             32'h6);
    check("mis.valid",   {31'd0, ir_valid},    32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    cyc(2);
    redirect_valid = 1'b0;
    check("mis.addr",    imem_addr, 32'h6);
    check("mis.fpc2",    fault_pc,  32'h6);
    do_reset();

    // Misaligned near the top, then out of range
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FE;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    check("3fe.fault",   {31'd0, fetch_fault}, 32'd1);
    check("3fe.faultpc", fault_pc,             32'h3FE);
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    check("400.fault",   {31'd0, fetch_fault}, 32'd1);
    check("400.faultpc", fault_pc,             32'h400);
    do_reset();

    // Reset in the same cycle as a handshake and a redirect
    ir_ready = 1'b1;
    cyc(3);
    check("rm.valid",  {31'd0, ir_valid}, 32'd1);
    check("rm.count",  fetch_count,       32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    resetn         = 1'b0;
    cyc(1);
    redirect_valid = 1'b0;
    ir_ready       = 1'b0;
    check("rm.count0", fetch_count,       32'd0);
    check("rm.pc",     imem_addr,         RESET_PC);
    check("rm.ir",     ir,                32'h0000_0013);
    check("rm.valid0", {31'd0, ir_valid}, 32'd0);
    resetn = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32 multicycle core. Sits directly upstream of the instruction memory and drives its byte address.
- Holds the architectural PC and samples the combinational instruction read into an instruction register (IR).
- Presents {IR, PC-of-IR} to decode/control through a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump) and flags misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 1024, byte size of the instruction memory. A legal fetch address satisfies addr + 3 < MEM_BYTES.
- NOP_INSTR, 32'h0000_0013, IR reset value (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- imem_addr  output  32  byte address to the instruction memory; always equals the PC register.
- imem_rdata  input  32  little-endian instruction word from the memory, combinational from imem_addr.
- ir_valid  output  1  IR and ir_pc hold an instruction for decode.
- ir_ready  input  1  decode accepts the IR this cycle.
- ir  output  32  latched instruction.
- ir_pc  output  32  byte address the IR was fetched from.
- redirect_valid  input  1  single-cycle request to load a new PC.
- redirect_pc  input  32  target PC for the redirect.
- fetch_fault  output  1  sticky fault flag.
- fault_pc  output  32  PC that caused the fault.
- fetch_count  output  32  number of accepted handshakes (ir_valid & ir_ready).

Behaviour:
- Reset (resetn=0 at a posedge): the following registers load these values; reset has priority over every other event, including mid-fetch or mid-handshake.
  - pc = RESET_PC
  - state = FETCH
  - ir = NOP_INSTR
  - ir_pc = 0
  - ir_valid = 0
  - fetch_fault = 0
  - fault_pc = 0
  - fetch_count = 0
- States: FETCH, VALID, FAULT. ir_valid = (state == VALID), registered.
- Decision priority, evaluated each cycle: (1) redirect_valid, (2) fault check, (3) FETCH/VALID action.
- FETCH:
  - If pc[1:0] != 0 or pc + 3 >= MEM_BYTES: go to FAULT, set fetch_fault = 1 and fault_pc = pc. IR is unchanged.
  - Otherwise: ir <= imem_rdata, ir_pc <= pc, pc <= pc + 4 (mod 2^32, wraps silently), go to VALID.
  - Fetch latency: 1 cycle from entering FETCH to ir_valid = 1.
- VALID:
  - ir, ir_pc and ir_valid are held stable while ir_ready = 0.
  - On ir_ready = 1: fetch_count += 1 (wraps at 2^32), go to FETCH.
  - Sustained throughput is 1 instruction per 2 cycles. This is intentional for the multicycle core.
- Redirect, allowed in any state other than FAULT:
  - pc <= redirect_pc and state <= FETCH.
  - ir_valid deasserts the next cycle; the pending IR is discarded.
  - If ir_ready is also 1 in VALID, the handshake still counts (fetch_count increments) and decode keeps that instruction.
  - An illegal redirect_pc is not checked on the redirect cycle. It faults in the following FETCH cycle.
- FAULT:
  - Terminal: ir_valid = 0, PC frozen, redirect_valid ignored.
  - Left only via reset.
  - imem_addr keeps driving the faulting PC.
- imem_addr is driven from the PC register only. There is no combinational path from redirect_pc to imem_addr.
- No X on outputs after the first reset cycle.
- The instruction memory contents are only valid after reset, so fetch begins on the first cycle with resetn = 1.

Test Plan:
- Reset then streaming, memory preloaded, ir_ready = 1:
  - cycle 1 after reset: ir = 32'h0000_2083, ir_pc = 0.
  - next valid: ir = 32'h0010_8133, ir_pc = 4.
  - ir_valid pattern 0,1,0,1.
  - fetch_count = 2 after the second handshake.
- Backpressure: hold ir_ready = 0 for 5 cycles in VALID.
  - ir = 32'h0000_2083 and ir_pc = 0 stay constant, fetch_count stays 0.
  - After ir_ready = 1: next fetch from pc = 4.
- Redirect in VALID with ir_ready = 0, redirect_pc = 32'h30:
  - ir_valid = 0 next cycle.
  - Following cycle: ir = 32'h0095_0A63, ir_pc = 32'h30.
  - fetch_count unchanged.
- Misaligned redirect, redirect_pc = 32'h6:
  - One FETCH cycle later: fetch_fault = 1, fault_pc = 6, ir_valid = 0.
  - Further redirects are ignored.
  - After resetn = 0 for one cycle: fetch_fault = 0, pc = RESET_PC.
- Out-of-range, redirect_pc = 32'h3FC (1020): fetches legally, since 1020 + 3 < 1024.
- Out-of-range, redirect_pc = 32'h3FE: fault, misaligned.
- Out-of-range, redirect_pc = 32'h400: fault, out of range; fault_pc = 32'h400.
- Reset mid-handshake: assert resetn = 0 in the same cycle as ir_ready = 1 and redirect_valid = 1.
  - Reset wins: fetch_count = 0, pc = RESET_PC, ir = 32'h0000_0013, ir_valid = 0.
